xtal_startup_ctrl: RTL and testbench
====================================

XTAL_STARTUP_CTRL -- requirements
Module: xtal_startup_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the startup edge counter and of STARTUP_CYC.
REQ-002 Parameter TO_W, default 8: width of the edge-gap timer; timeout is 2^TO_W-1 CLK cycles.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2: synchroniser depth for XCLK.
REQ-004 CLK  input  1: single block clock (free-running RC clock); one clock; all state on its rising edge.
REQ-005 RESETN  input  1: reset, asynchronous assert, active-low.
REQ-006 XCLK  input  1: crystal oscillator digital output, asynchronous to CLK; CLK SHALL be at least 4x XCLK frequency.
REQ-007 EN  input  1: request oscillator operation.
REQ-008 BYPASS  input  1: external clock driven on XI; amplifier stays off.
REQ-009 STARTUP_CYC  input  CNT_W: XCLK rising edges required before READY.
REQ-010 XEN  output  1: oscillator amplifier enable.
REQ-011 READY  output  1: crystal clock stable and usable.
REQ-012 FAIL  output  1: startup or loss-of-clock failure latched.
REQ-013 STATE  output  3: encoded FSM state.

Function
REQ-014 XCLK SHALL pass through SYNC_STAGES flops; an edge event is synced value 1 with previous synced value 0; edge-to-event latency SYNC_STAGES+1 CLK cycles.
REQ-015 States: OFF=0, WAIT=1, COUNT=2, RUN=3, FAIL=4; codes 5-7 SHALL return to OFF next cycle.
REQ-016 OFF: XEN=0, READY=0, FAIL=0, counters cleared; EN=1 -> WAIT next cycle, STARTUP_CYC captured on this transition.
REQ-017 WAIT: XEN=~BYPASS; gap timer increments per CLK; edge event -> COUNT with edge count 1 (BYPASS=1: edge event -> RUN directly).
REQ-018 COUNT: each edge event increments edge count and clears gap timer; edge count reaching captured STARTUP_CYC -> RUN; captured value 0 or 1 -> RUN on first edge.
REQ-019 WAIT or COUNT: gap timer reaching 2^TO_W-1 without an edge event -> FAIL.
REQ-020 RUN: READY=1, XEN=~BYPASS; changes to STARTUP_CYC or BYPASS while not in OFF SHALL be ignored until OFF.
REQ-021 FAIL: XEN=0, READY=0, FAIL=1; held until EN=0.
REQ-022 EN=0 in any state -> OFF next cycle, overriding all other transitions including simultaneous edge or timeout.
REQ-023 Edge event and timeout in the same cycle: edge wins, timer clears.
REQ-024 Outputs SHALL be registered; READY rises the cycle after the RUN-entry transition decision, no combinational input-to-output paths.

Reset
REQ-025 RESETN low SHALL immediately force STATE=OFF, XEN=0, READY=0, FAIL=0, counters and synchroniser flops to 0.
REQ-026 Reset deassertion mid-startup SHALL restart from OFF; first edge detection requires a fresh 0->1 on synced XCLK.

Configuration
REQ-027 Macro XTAL_LOSS_WDOG_EN defined: in RUN the gap timer runs and clears on each edge event; reaching 2^TO_W-1 -> FAIL (READY drops, XEN=0).
REQ-028 Macro XTAL_LOSS_WDOG_EN undefined: RUN exits only on EN=0; gap timer held at 0 in RUN and watchdog logic absent.

Verification
REQ-029 Nominal: CLK 12 MHz, XCLK 1 MHz starting 20 us after EN, STARTUP_CYC=100 -> XEN=1 from WAIT, READY=1 within SYNC_STAGES+2 CLK of 100th XCLK rise, FAIL=0.
REQ-030 Dead crystal: TO_W=8, EN=1, XCLK stuck 0 -> FAIL=1 exactly 255 CLK after WAIT entry, XEN=0; EN=0 -> OFF, FAIL=0 next cycle.
REQ-031 Bypass: BYPASS=1, EN=1, XCLK toggling -> XEN stays 0, READY=1 after first synced edge; STARTUP_CYC=0 normal mode -> READY after first edge.
REQ-032 Loss of clock with XTAL_LOSS_WDOG_EN: RUN, XCLK stops -> FAIL=1 after 255 CLK; without macro READY stays 1 indefinitely.
REQ-033 Disruption: EN=0 coincident with 100th edge -> OFF, READY stays 0; RESETN pulsed in COUNT -> all outputs 0 asynchronously, restart counts from 1.

Source files
------------

// File: rtl/xtal_startup_ctrl.sv
// Crystal oscillator startup controller: enables the amplifier, counts synchronised XCLK edges,
// declares READY or latches a failure on edge-gap timeout. XTAL_LOSS_WDOG_EN adds a loss-of-clock watchdog in RUN.
module xtal_startup_ctrl #(
    parameter int CNT_W       = 16,
    parameter int TO_W        = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             XCLK,
    input  logic             EN,
    input  logic             BYPASS,
    input  logic [CNT_W-1:0] STARTUP_CYC,
    output logic             XEN,
    output logic             READY,
    output logic             FAIL,
    output logic [2:0]       STATE
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_WAIT  = 3'd1,
        S_COUNT = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    // Gap timer compares against one below all-ones so the failure lands on the all-ones cycle.
    localparam logic [TO_W-1:0] GAP_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    state_t             state_q, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               sync_d;
    logic               edge_ev;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_inc;
    logic [CNT_W-1:0]   cyc_q, cyc_n;
    logic [TO_W-1:0]    gap_q, gap_n;
    logic               byp_q, byp_n;
    logic               xen_n, ready_n, fail_n;

    assign edge_ev = sync_q[SYNC_STAGES-1] & ~sync_d;
    assign cnt_inc = cnt_q + 1'b1;
    assign STATE   = state_q;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        gap_n   = gap_q;
        cyc_n   = cyc_q;
        byp_n   = byp_q;
        case (state_q)
            S_OFF: begin
                cnt_n = '0;
                gap_n = '0;
                if (EN) begin
                    state_n = S_WAIT;
                    cyc_n   = STARTUP_CYC;
                    byp_n   = BYPASS;
                end
            end
            S_WAIT: begin
                if (edge_ev) begin
                    gap_n   = '0;
                    cnt_n   = CNT_W'(1);
                    state_n = (byp_q || cyc_q <= CNT_W'(1)) ? S_RUN : S_COUNT;
                end else if (gap_q == GAP_LAST) begin
                    state_n = S_FAIL;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
            S_COUNT: begin
                if (edge_ev) begin
                    gap_n = '0;
                    cnt_n = cnt_inc;
                    if (cnt_inc >= cyc_q) state_n = S_RUN;
                end else if (gap_q == GAP_LAST) begin
                    state_n = S_FAIL;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
            S_RUN: begin
`ifdef XTAL_LOSS_WDOG_EN
                if (edge_ev)               gap_n   = '0;
                else if (gap_q == GAP_LAST) state_n = S_FAIL;
                else                       gap_n   = gap_q + 1'b1;
`else
                gap_n = '0;
`endif
            end
            S_FAIL: begin
                gap_n = '0;
            end
            default: state_n = S_OFF;
        endcase
        // Dropping EN beats any edge or timeout decided this cycle.
        if (!EN) begin
            state_n = S_OFF;
            cnt_n   = '0;
            gap_n   = '0;
        end
        xen_n   = ~byp_n & (state_n == S_WAIT || state_n == S_COUNT || state_n == S_RUN);
        ready_n = (state_n == S_RUN);
        fail_n  = (state_n == S_FAIL);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_OFF;
            sync_q  <= '0;
            sync_d  <= 1'b0;
            cnt_q   <= '0;
            cyc_q   <= '0;
            gap_q   <= '0;
            byp_q   <= 1'b0;
            XEN     <= 1'b0;
            READY   <= 1'b0;
            FAIL    <= 1'b0;
        end else begin
            state_q <= state_n;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], XCLK};
            sync_d  <= sync_q[SYNC_STAGES-1];
            cnt_q   <= cnt_n;
            cyc_q   <= cyc_n;
            gap_q   <= gap_n;
            byp_q   <= byp_n;
            XEN     <= xen_n;
            READY   <= ready_n;
            FAIL    <= fail_n;
        end
    end

endmodule

// File: tb/tb_xtal_startup_ctrl.sv
// Bench for xtal_startup_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with literal timing expectations.
module tb_xtal_startup_ctrl;
    localparam int SYNC = 2;
    localparam int TMAX = 255;
    localparam int M_OFF = 0, M_WAIT = 1, M_COUNT = 2, M_RUN = 3, M_FAILED = 4;

    logic        CLK, RESETN, XCLK, EN, BYPASS;
    logic [15:0] STARTUP_CYC;
    logic        XEN, READY, FAIL;
    logic [2:0]  STATE;

    int checks = 0, failures = 0;

    xtal_startup_ctrl #(.CNT_W(16), .TO_W(8), .SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .RESETN(RESETN), .XCLK(XCLK), .EN(EN), .BYPASS(BYPASS),
        .STARTUP_CYC(STARTUP_CYC), .XEN(XEN), .READY(READY), .FAIL(FAIL), .STATE(STATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // XCLK generator: period in CLK cycles, counts rising edges since start.
    int xper = 12, xph = 0, xrise = 0;
    bit xrun = 1'b0;
    initial begin
        bit nv;
        XCLK = 1'b0;
        forever begin
            @(negedge CLK);
            if (xrun) begin
                xph = (xph + 1) % xper;
                nv  = (xph < xper / 2);
                if (nv && !XCLK) xrise++;
                XCLK = nv;
            end else begin
                XCLK = 1'b0;
            end
        end
    end

    task automatic start_x(input int per);
        xper  = per;
        xph   = per - 1;
        xrise = 0;
        xrun  = 1'b1;
    endtask

    task automatic wait_rise(input int n);
        for (int i = 0; i < 5000; i++) begin
            @(posedge CLK);
            if (xrise >= n) break;
        end
        if (xrise < n) chk("rise_timeout", xrise, n);
    endtask

    task automatic ready_within(input string name, input int lim);
        for (int i = 0; i < lim && !READY; i++) @(negedge CLK);
        chk(name, int'(READY), 1);
    endtask

    // Behavioural model: XCLK history, edges seen and idle cycles since the last edge.
    int m_mode = M_OFF, m_edges = 0, m_idle = 0, m_cap = 0;
    bit m_byp = 1'b0;
    bit hq[$];
    initial begin
        forever begin
            @(posedge CLK or negedge RESETN);
            if (!RESETN) begin
                m_mode = M_OFF; m_edges = 0; m_idle = 0; m_byp = 1'b0;
                hq.delete();
            end else begin
                bit ev;
                int s, need;
                hq.push_back(XCLK);
                s  = hq.size();
                // An edge is acted on SYNC cycles after XCLK is first sampled high.
                ev = (s > SYNC && hq[s-1-SYNC]) && !(s > SYNC + 1 && hq[s-2-SYNC]);
                if (s > SYNC + 4) void'(hq.pop_front());
                need = m_byp ? 1 : (m_cap < 1 ? 1 : m_cap);
                if (!EN) begin
                    m_mode = M_OFF; m_edges = 0; m_idle = 0;
                end else if (m_mode == M_OFF) begin
                    m_mode = M_WAIT; m_cap = int'(STARTUP_CYC); m_byp = BYPASS;
                    m_edges = 0; m_idle = 0;
                end else if (m_mode == M_WAIT || m_mode == M_COUNT) begin
                    if (ev) begin
                        m_edges++; m_idle = 0;
                        m_mode = (m_edges >= need) ? M_RUN : M_COUNT;
                    end else begin
                        m_idle++;
                        if (m_idle >= TMAX) m_mode = M_FAILED;
                    end
                end else if (m_mode == M_RUN) begin
`ifdef XTAL_LOSS_WDOG_EN
                    if (ev) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle >= TMAX) m_mode = M_FAILED;
                    end
`endif
                end
            end
        end
    end

    initial begin
        logic [5:0] e, a;
        forever begin
            @(negedge CLK);
            e = {3'(m_mode),
                 !m_byp && (m_mode == M_WAIT || m_mode == M_COUNT || m_mode == M_RUN),
                 m_mode == M_RUN, m_mode == M_FAILED};
            a = {STATE, XEN, READY, FAIL};
            chk("model_state_xen_ready_fail", int'(a), int'(e));
        end
    end

    initial begin
        RESETN = 1'b0; EN = 1'b0; BYPASS = 1'b0; STARTUP_CYC = '0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", int'({STATE, XEN, READY, FAIL}), 0);
        RESETN = 1'b1;
        @(negedge CLK);

        // Dead crystal: failure exactly 255 cycles after WAIT entry.
        EN = 1'b1;
        @(negedge CLK);
        chk("wait_entry_state", int'(STATE), 1);
        chk("wait_entry_xen", int'(XEN), 1);
        repeat (254) @(negedge CLK);
        chk("dead_flag_at_254", int'(FAIL), 0);
        @(negedge CLK);
        chk("dead_flag_at_255", int'(FAIL), 1);
        chk("dead_xen", int'(XEN), 0);
        chk("dead_state", int'(STATE), 4);
        EN = 1'b0;
        @(negedge CLK);
        chk("dead_off_state", int'(STATE), 0);
        chk("dead_off_flag", int'(FAIL), 0);

        // Nominal startup, 100 edges; mid-count STARTUP_CYC change ignored.
        STARTUP_CYC = 16'd100; EN = 1'b1;
        repeat (100) @(negedge CLK);
        start_x(12);
        wait_rise(10);
        @(negedge CLK);
        STARTUP_CYC = 16'd5;
        wait_rise(50);
        @(negedge CLK);
        chk("count_ignores_cyc_change", int'(READY), 0);
        chk("count_state", int'(STATE), 2);
        wait_rise(100);
        ready_within("nominal_ready", SYNC + 2);
        chk("nominal_xen", int'(XEN), 1);
        chk("nominal_flag", int'(FAIL), 0);

        // Loss of clock in RUN.
        @(negedge CLK);
        xrun = 1'b0;
        repeat (300) @(negedge CLK);
`ifdef XTAL_LOSS_WDOG_EN
        chk("loss_flag", int'(FAIL), 1);
        chk("loss_ready", int'(READY), 0);
        chk("loss_xen", int'(XEN), 0);
`else
        chk("loss_ready_held", int'(READY), 1);
        chk("loss_xen_held", int'(XEN), 1);
`endif
        EN = 1'b0;
        repeat (2) @(negedge CLK);

        // Bypass: amplifier off, ready on first edge, BYPASS change ignored.
        BYPASS = 1'b1; STARTUP_CYC = 16'd100; EN = 1'b1;
        repeat (5) @(negedge CLK);
        chk("bypass_xen_wait", int'(XEN), 0);
        start_x(8);
        wait_rise(1);
        ready_within("bypass_ready", SYNC + 2);
        chk("bypass_xen_run", int'(XEN), 0);
        @(negedge CLK);
        BYPASS = 1'b0;
        repeat (3) @(negedge CLK);
        chk("bypass_latched", int'(XEN), 0);
        EN = 1'b0; xrun = 1'b0;
        repeat (3) @(negedge CLK);

        // STARTUP_CYC=0 in normal mode: ready on first edge.
        STARTUP_CYC = 16'd0; EN = 1'b1;
        repeat (5) @(negedge CLK);
        start_x(8);
        wait_rise(1);
        ready_within("cyc0_ready", SYNC + 2);
        chk("cyc0_xen", int'(XEN), 1);
        @(negedge CLK);
        EN = 1'b0; xrun = 1'b0;
        repeat (3) @(negedge CLK);

        // EN dropped on the cycle the 100th edge is acted on.
        STARTUP_CYC = 16'd100; EN = 1'b1;
        repeat (5) @(negedge CLK);
        start_x(8);
        wait_rise(100);
        @(negedge CLK);
        @(negedge CLK);
        EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("coincident_ready_low", int'(READY), 0);
        end
        chk("coincident_state_off", int'(STATE), 0);
        xrun = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset pulse in COUNT: immediate clear, count restarts from 1.
        STARTUP_CYC = 16'd20; EN = 1'b1;
        repeat (5) @(negedge CLK);
        start_x(12);
        wait_rise(10);
        @(negedge CLK);
        xrun = 1'b0;
        #2 RESETN = 1'b0;
        #1 chk("async_reset_outputs", int'({STATE, XEN, READY, FAIL}), 0);
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (10) @(negedge CLK);
        start_x(12);
        wait_rise(19);
        @(negedge CLK);
        chk("restart_not_ready_19", int'(READY), 0);
        wait_rise(20);
        ready_within("restart_ready", SYNC + 2);

        @(negedge CLK);
        EN = 1'b0; xrun = 1'b0;
        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
